vga_timing_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_sync_delay.sv | 26 ++
 rtl/vga_timing_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel/sync types and scan-state encoding for the VGA timing controller.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_FETCH_LEAD = 2;

  localparam int COORD_W = 10;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic frame_start;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register that delays the decoded lead timing so it lines up with returned pixels.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = DEF_FETCH_LEAD
) (
  input  logic  CLOCK_25,
  input  logic  reset,
  input  sync_t i_sync,
  output sync_t o_sync
);

  sync_t r_pipe [DEPTH];

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= SYNC_IDLE;
    end else begin
      r_pipe[0] <= i_sync;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_sync = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA scan controller: lead counters issue framebuffer fetches, delayed decode drives sync/RGB.
// Optional VGA_VBLANK_IRQ_EN adds a sticky start-of-vertical-blank interrupt (irq / irq_ack).
//
// state | meaning
// IDLE  | outputs at reset values, counters held at 0
// RUN   | free-running scan
// DRAIN | scan to end of frame, then FETCH_LEAD tail cycles to empty the pipeline
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int FETCH_LEAD = DEF_FETCH_LEAD
) (
  input  logic                CLOCK_25,
  input  logic                reset,
  input  logic                enable,
  output logic                fetch_req,
  output logic [COORD_W-1:0]  fetch_x,
  output logic [COORD_W-1:0]  fetch_y,
  input  logic [23:0]         pix_in,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                frame_start,
  output logic                busy
`ifdef VGA_VBLANK_IRQ_EN
  ,
  input  logic                irq_ack,
  output logic                irq
`endif
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] HA_C   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] VA_C   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [2:0]         TAIL_LOAD = 3'(FETCH_LEAD - 1);

  state_t               r_state, w_state_nxt;
  logic [COORD_W-1:0]   r_lh, r_lv, w_lh_nxt, w_lv_nxt;
  logic                 r_tail, w_tail_nxt;
  logic [2:0]           r_tail_cnt, w_tail_cnt_nxt;
  logic                 w_last, w_scan, w_scan_nxt, w_fetch_nxt;
  sync_t                w_sync_in, w_sync_dly;
  rgb888_t              w_pix;

  assign w_last = (r_lh == H_LAST) && (r_lv == V_LAST);
  assign w_pix  = pix_in;

  always_ff @(posedge CLOCK_25) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_tail marks the post-frame cycles in DRAIN where only the delay pipeline is still emptying.
  always_comb begin
    w_state_nxt    = r_state;
    w_tail_nxt     = r_tail;
    w_tail_cnt_nxt = r_tail_cnt;
    case (r_state)
      IDLE: if (enable) w_state_nxt = RUN;
      RUN:  if (!enable) w_state_nxt = DRAIN;
      DRAIN: begin
        if (r_tail) begin
          if (r_tail_cnt == 3'd0) begin
            w_state_nxt = IDLE;
            w_tail_nxt  = 1'b0;
          end else begin
            w_tail_cnt_nxt = r_tail_cnt - 3'd1;
          end
        end else if (enable) begin
          w_state_nxt = RUN;
        end else if (w_last) begin
          w_tail_nxt     = 1'b1;
          w_tail_cnt_nxt = TAIL_LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_scan     = (r_state == RUN) || ((r_state == DRAIN) && !r_tail);
  assign w_scan_nxt = (w_state_nxt == RUN) || ((w_state_nxt == DRAIN) && !w_tail_nxt);

  always_comb begin
    w_lh_nxt = '0;
    w_lv_nxt = '0;
    if (w_scan) begin
      if (r_lh == H_LAST) begin
        w_lv_nxt = (r_lv == V_LAST) ? '0 : r_lv + 1'b1;
      end else begin
        w_lh_nxt = r_lh + 1'b1;
        w_lv_nxt = r_lv;
      end
    end
  end

  // Fetch is computed from next-cycle coordinates so the registered strobe lines up with r_lh/r_lv.
  assign w_fetch_nxt = w_scan_nxt && (w_lh_nxt < HA_C) && (w_lv_nxt < VA_C);

  always_comb begin
    w_sync_in             = SYNC_IDLE;
    w_sync_in.active      = w_scan && (r_lh < HA_C) && (r_lv < VA_C);
    w_sync_in.hs_n        = !(w_scan && (r_lh >= HS_BEG) && (r_lh < HS_END));
    w_sync_in.vs_n        = !(w_scan && (r_lv >= VS_BEG) && (r_lv < VS_END));
    w_sync_in.frame_start = w_scan && (r_lh == '0) && (r_lv == '0);
  end

  vga_sync_delay #(.DEPTH(FETCH_LEAD)) u_sync_delay (
    .CLOCK_25 (CLOCK_25),
    .reset    (reset),
    .i_sync   (w_sync_in),
    .o_sync   (w_sync_dly)
  );

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_lh        <= '0;
      r_lv        <= '0;
      r_tail      <= 1'b0;
      r_tail_cnt  <= '0;
      fetch_req   <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      r_lh        <= w_lh_nxt;
      r_lv        <= w_lv_nxt;
      r_tail      <= w_tail_nxt;
      r_tail_cnt  <= w_tail_cnt_nxt;
      fetch_req   <= w_fetch_nxt;
      if (w_fetch_nxt) begin
        fetch_x <= w_lh_nxt;
        fetch_y <= w_lv_nxt;
      end
      VGA_HS      <= w_sync_dly.hs_n;
      VGA_VS      <= w_sync_dly.vs_n;
      VGA_BLANK_N <= w_sync_dly.active;
      VGA_R       <= w_sync_dly.active ? w_pix.r : 8'h00;
      VGA_G       <= w_sync_dly.active ? w_pix.g : 8'h00;
      VGA_B       <= w_sync_dly.active ? w_pix.b : 8'h00;
      frame_start <= w_sync_dly.frame_start;
    end
  end

  assign busy = (r_state != IDLE);

`ifdef VGA_VBLANK_IRQ_EN
  logic                  w_vbl_lead;
  logic [FETCH_LEAD-1:0] r_vbl_pipe;

  assign w_vbl_lead = w_scan && (r_lh == '0) && (r_lv == VA_C);

  // Set has priority over a coincident acknowledge.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_vbl_pipe <= '0;
      irq        <= 1'b0;
    end else begin
      r_vbl_pipe[0] <= w_vbl_lead;
      for (int i = 1; i < FETCH_LEAD; i++) r_vbl_pipe[i] <= r_vbl_pipe[i-1];
      if (r_vbl_pipe[FETCH_LEAD-1]) irq <= 1'b1;
      else if (irq_ack)             irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a reduced frame geometry, checked cycle by cycle against a frame-position model.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int FL = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int N  = HT * VT;

  logic        CLOCK_25 = 1'b0;
  logic        reset, enable;
  logic        fetch_req;
  logic [9:0]  fetch_x, fetch_y;
  logic [23:0] pix_in;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start, busy;
`ifdef VGA_VBLANK_IRQ_EN
  logic        irq_ack, irq;
`endif

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FETCH_LEAD(FL)
  ) dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .enable      (enable),
    .fetch_req   (fetch_req),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .pix_in      (pix_in),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start),
    .busy        (busy)
`ifdef VGA_VBLANK_IRQ_EN
    ,
    .irq_ack     (irq_ack),
    .irq         (irq)
`endif
  );

  initial forever #20 CLOCK_25 = ~CLOCK_25;

  int n_chk = 0, n_pass = 0;

  // Model: mode 0 idle, 1 run, 2 drain, 3 post-frame tail; p is the lead position within the frame.
  int mode = 0, p = 0, tail_left = 0;
  int hist [FL+2];
  int exp_fx = 0, exp_fy = 0;
  logic exp_irq = 1'b0;
  logic [7:0] salt;
  logic       req_h [FL+1];
  logic [9:0] x_h [FL+1];
  logic [9:0] y_h [FL+1];
  int cnt_req = 0, cnt_fs = 0, cnt_hs = 0, cnt_vs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic cyc();
    logic en_s, rs_s, ack_s;
    int lead, d, dh, dv;
    logic ereq, dact, ehs, evs;
    logic [23:0] ergb;
    en_s = enable;
    rs_s = reset;
    ack_s = 1'b0;
`ifdef VGA_VBLANK_IRQ_EN
    ack_s = irq_ack;
`endif
    @(posedge CLOCK_25);
    #1;
    if (rs_s) begin
      mode = 0; p = 0; tail_left = 0;
      for (int k = 0; k < FL + 2; k++) hist[k] = -1;
      exp_fx = 0; exp_fy = 0; exp_irq = 1'b0;
    end else begin
      case (mode)
        0: if (en_s) begin mode = 1; p = 0; end
        1: begin p = (p + 1) % N; if (!en_s) mode = 2; end
        2: if (p == N - 1 && !en_s) begin mode = 3; tail_left = FL; end
           else begin p = (p + 1) % N; if (en_s) mode = 1; end
        default: begin tail_left--; if (tail_left == 0) mode = 0; end
      endcase
      for (int k = FL + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = (mode == 1 || mode == 2) ? p : -1;
    end
    lead = hist[0];
    ereq = (lead >= 0) && (lead % HT < HA) && (lead / HT < VA);
    if (ereq) begin exp_fx = lead % HT; exp_fy = lead / HT; end
    d  = hist[FL+1];
    dh = (d >= 0) ? d % HT : 0;
    dv = (d >= 0) ? d / HT : 0;
    dact = (d >= 0) && (dh < HA) && (dv < VA);
    ehs  = !((d >= 0) && (dh >= HA + HFP) && (dh < HA + HFP + HSW));
    evs  = !((d >= 0) && (dv >= VA + VFP) && (dv < VA + VFP + VSW));
    ergb = dact ? {8'(dh), 8'(dv), salt} : 24'h0;
    if (!rs_s) begin
      if (d == VA * HT) exp_irq = 1'b1;
      else if (ack_s)   exp_irq = 1'b0;
    end
    chk("fetch_req", 32'(fetch_req), 32'(ereq));
    chk("fetch_x", 32'(fetch_x), 32'(exp_fx));
    chk("fetch_y", 32'(fetch_y), 32'(exp_fy));
    chk("hs", 32'(VGA_HS), 32'(ehs));
    chk("vs", 32'(VGA_VS), 32'(evs));
    chk("blank_n", 32'(VGA_BLANK_N), 32'(dact));
    chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(ergb));
    chk("frame_start", 32'(frame_start), 32'(d == 0));
    chk("busy", 32'(busy), 32'(mode != 0));
`ifdef VGA_VBLANK_IRQ_EN
    chk("irq", 32'(irq), 32'(exp_irq));
    irq_ack = ($urandom_range(0, 7) == 0);
`endif
    if (fetch_req === 1'b1)   cnt_req++;
    if (frame_start === 1'b1) cnt_fs++;
    if (VGA_HS === 1'b0)      cnt_hs++;
    if (VGA_VS === 1'b0)      cnt_vs++;
    for (int k = FL; k > 0; k--) begin
      req_h[k] = req_h[k-1]; x_h[k] = x_h[k-1]; y_h[k] = y_h[k-1];
    end
    req_h[0] = fetch_req; x_h[0] = fetch_x; y_h[0] = fetch_y;
    pix_in = (req_h[FL] === 1'b1) ? {x_h[FL][7:0], y_h[FL][7:0], salt} : 24'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 3 * N) begin cyc(); i++; end
    chk(tag, 32'(busy), 32'(0));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pix_in = '0;
`ifdef VGA_VBLANK_IRQ_EN
    irq_ack = 1'b0;
`endif
    salt = 8'($urandom);
    for (int k = 0; k < FL + 2; k++) hist[k] = -1;
    for (int k = 0; k <= FL; k++) begin req_h[k] = 1'b0; x_h[k] = '0; y_h[k] = '0; end
    run(3);
    reset = 1'b0;
    run(4);

    // Two full frames from idle: aggregate fetch/sync/frame counts.
    cnt_req = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
    enable = 1'b1;
    run(2 * N);
    chk("fetch_count_2frames", 32'(cnt_req), 32'(2 * HA * VA));
    chk("frame_start_count", 32'(cnt_fs), 32'(2));
    chk("hs_low_cycles", 32'(cnt_hs), 32'(2 * VT * HSW));
    chk("vs_low_cycles", 32'(cnt_vs), 32'(2 * VSW * HT));

    // Drop enable at a random point; the frame must finish and the block go idle.
    run($urandom_range(0, N - 1));
    enable = 1'b0;
    wait_idle("drain_to_idle");
    run(5);

    // Re-raise during drain: scan continues without a restart.
    enable = 1'b1;
    run($urandom_range(HT, 3 * HT));
    enable = 1'b0;
    run($urandom_range(1, N / 2));
    enable = 1'b1;
    run(N + $urandom_range(0, HT));

    // Random one-cycle enable drops.
    for (int i = 0; i < 4 * N; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      cyc();
    end
    enable = 1'b1;
    run($urandom_range(5 * HT, 6 * HT));

    // Mid-line reset aborts immediately.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(N + 7);
    enable = 1'b0;
    wait_idle("final_idle");
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
